// File: rtl/ota_boot_sequencer.sv
// OTA boot sequencer: parses a SYNC/CMD/ARG/CHK boot frame from the SPI byte
// stream, validates it, waits a programmable arm delay (abortable by any byte)
// and then fires a single-cycle multiboot trigger with the resolved slot address.
module ota_boot_sequencer #(
    parameter logic [7:0]  SYNC_BYTE    = 8'h5A,
    parameter int unsigned BYTE_TIMEOUT = 250000,
    parameter int unsigned ARM_DELAY    = 25000,
    parameter logic [31:0] SLOT_BASE    = 32'h0010_0000,
    parameter logic [31:0] SLOT_STRIDE  = 32'h0010_0000,
    parameter int unsigned NUM_SLOTS    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        boot_trigger,
    output logic [31:0] boot_address,
    output logic        busy,
    output logic        err_flag,
    output logic [2:0]  err_code,
    output logic [7:0]  err_count
);

    localparam int TO_W  = $clog2(BYTE_TIMEOUT + 1);
    localparam int ARM_W = $clog2(ARM_DELAY + 1);

    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(BYTE_TIMEOUT);
    localparam logic [TO_W-1:0]  GAP_ONE  = TO_W'(1);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_DELAY - 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
    localparam logic [ARM_W-1:0] ARM_ZERO = ARM_W'(0);

    localparam logic [7:0] CMD_BOOT  = 8'hB0;
    localparam logic [7:0] CMD_CLEAR = 8'hC1;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CHKSUM  = 3'd1;
    localparam logic [2:0] ERR_CMD     = 3'd2;
    localparam logic [2:0] ERR_SLOT    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_ABORT   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CMD = 3'd1,
        ST_GET_ARG = 3'd2,
        ST_GET_CHK = 3'd3,
        ST_ARM     = 3'd4,
        ST_FIRE    = 3'd5,
        ST_LOCKED  = 3'd6
    } state_t;

    // Flash address of a slot; the product wraps at 32 bits by design.
    function automatic logic [31:0] slot_address(input logic [7:0] slot);
        return SLOT_BASE + ({24'd0, slot} * SLOT_STRIDE);
    endfunction

    state_t           state_r, next_s;
    logic [7:0]       cmd_r, arg_r;
    logic [TO_W-1:0]  gap_r;
    logic [ARM_W-1:0] arm_r;
    logic             boot_trigger_r, busy_r, err_flag_r;
    logic [31:0]      boot_address_r;
    logic [2:0]       err_code_r;
    logic [7:0]       err_count_r;

    logic             in_frame_s, timeout_s, raise_s, clear_s, accept_s;
    logic [2:0]       raise_code_s;

    assign in_frame_s = (state_r == ST_GET_CMD) || (state_r == ST_GET_ARG) ||
                        (state_r == ST_GET_CHK);
    assign timeout_s  = (gap_r == TO_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode plus error/clear/accept strobes for the datapath.
    always_comb begin
        next_s       = state_r;
        raise_s      = 1'b0;
        raise_code_s = ERR_NONE;
        clear_s      = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    next_s = ST_GET_CMD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_GET_CMD, ST_GET_ARG, ST_GET_CHK: begin
                // A byte landing on the timeout cycle takes precedence.
                if (rx_valid) begin
                    if (state_r == ST_GET_CMD) begin
                        next_s = ST_GET_ARG;
                    end else if (state_r == ST_GET_ARG) begin
                        next_s = ST_GET_CHK;
                    end else if (rx_data != (cmd_r ^ arg_r)) begin
                        next_s = ST_IDLE; raise_s = 1'b1; raise_code_s = ERR_CHKSUM;
                    end else if ((cmd_r != CMD_BOOT) && (cmd_r != CMD_CLEAR)) begin
                        next_s = ST_IDLE; raise_s = 1'b1; raise_code_s = ERR_CMD;
                    end else if ((cmd_r == CMD_BOOT) && ({24'd0, arg_r} >= 32'(NUM_SLOTS))) begin
                        next_s = ST_IDLE; raise_s = 1'b1; raise_code_s = ERR_SLOT;
                    end else if (cmd_r == CMD_CLEAR) begin
                        next_s = ST_IDLE; clear_s = 1'b1;
                    end else begin
                        next_s = ST_ARM; accept_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    next_s = ST_IDLE; raise_s = 1'b1; raise_code_s = ERR_TIMEOUT;
                end else begin
                    next_s = state_r;
                end
            end
            ST_ARM: begin
                if (rx_valid) begin
                    next_s = ST_IDLE; raise_s = 1'b1; raise_code_s = ERR_ABORT;
                end else if (arm_r == ARM_ZERO) begin
                    next_s = ST_FIRE;
                end else begin
                    next_s = ST_ARM;
                end
            end
            ST_FIRE:   next_s = ST_LOCKED;
            ST_LOCKED: next_s = ST_LOCKED;
            default:   next_s = ST_IDLE;
        endcase
    end

    // Frame capture, inter-byte gap counter and arm countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r <= 8'd0;
            arg_r <= 8'd0;
            gap_r <= '0;
            arm_r <= '0;
        end else begin
            if ((state_r == ST_GET_CMD) && rx_valid) begin
                cmd_r <= rx_data;
            end
            if ((state_r == ST_GET_ARG) && rx_valid) begin
                arg_r <= rx_data;
            end
            if (in_frame_s && !rx_valid && !timeout_s) begin
                gap_r <= gap_r + GAP_ONE;
            end else begin
                gap_r <= '0;
            end
            if (accept_s) begin
                arm_r <= ARM_LOAD;
            end else if ((state_r == ST_ARM) && (arm_r != ARM_ZERO)) begin
                arm_r <= arm_r - ARM_ONE;
            end
        end
    end

    // Registered outputs: trigger, address, busy and the sticky error block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_trigger_r <= 1'b0;
            boot_address_r <= 32'd0;
            busy_r         <= 1'b0;
            err_flag_r     <= 1'b0;
            err_code_r     <= ERR_NONE;
            err_count_r    <= 8'd0;
        end else begin
            boot_trigger_r <= (state_r == ST_FIRE);
            busy_r         <= (next_s != ST_IDLE);
            if (accept_s) begin
                boot_address_r <= slot_address(arg_r);
            end
            if (raise_s) begin
                err_flag_r  <= 1'b1;
                err_code_r  <= raise_code_s;
                err_count_r <= (err_count_r == 8'd255) ? 8'd255 : err_count_r + 8'd1;
            end else if (clear_s) begin
                err_flag_r  <= 1'b0;
                err_code_r  <= ERR_NONE;
                err_count_r <= 8'd0;
            end
        end
    end

    assign boot_trigger = boot_trigger_r;
    assign boot_address = boot_address_r;
    assign busy         = busy_r;
    assign err_flag     = err_flag_r;
    assign err_code     = err_code_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_ota_boot_sequencer.sv
// Bench for ota_boot_sequencer: two instances (arm delay 4 and 100, byte
// timeout 16) share one byte stream; a frame-level model predicts every output
// each cycle and directed literal checks pin the model.
module tb_ota_boot_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        trig   [2];
    logic [31:0] addr   [2];
    logic        busy_o [2];
    logic        flag   [2];
    logic [2:0]  code   [2];
    logic [7:0]  cnt    [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int trig_seen [2];

    // model state
    int          m_pos    [2];
    logic [7:0]  m_cmd    [2];
    logic [7:0]  m_arg    [2];
    int          m_gap    [2];
    bit          m_armed  [2];
    int          m_e0     [2];
    bit          m_locked [2];
    bit          m_trig   [2];
    logic [31:0] m_addr   [2];
    bit          m_flag   [2];
    int          m_code   [2];
    int          m_cnt    [2];

    ota_boot_sequencer #(.ARM_DELAY(4), .BYTE_TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .boot_trigger(trig[0]), .boot_address(addr[0]), .busy(busy_o[0]),
        .err_flag(flag[0]), .err_code(code[0]), .err_count(cnt[0]));

    ota_boot_sequencer #(.ARM_DELAY(100), .BYTE_TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .boot_trigger(trig[1]), .boot_address(addr[1]), .busy(busy_o[1]),
        .err_flag(flag[1]), .err_code(code[1]), .err_count(cnt[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic raise(input int i, input int c);
        m_flag[i] = 1'b1;
        m_code[i] = c;
        m_cnt[i]  = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
    endtask

    // Frame-level reference: consumes the inputs seen at one rising edge.
    task automatic model_step(input int i);
        int ad;
        ad = (i == 0) ? 4 : 100;
        if (!rst_n) begin
            m_pos[i] = 0; m_gap[i] = 0; m_armed[i] = 1'b0; m_locked[i] = 1'b0;
            m_trig[i] = 1'b0; m_addr[i] = 32'd0; m_flag[i] = 1'b0;
            m_code[i] = 0; m_cnt[i] = 0; m_cmd[i] = 8'd0; m_arg[i] = 8'd0;
        end else begin
            m_trig[i] = 1'b0;
            if (m_locked[i]) begin
                m_trig[i] = 1'b0;
            end else if (m_armed[i]) begin
                if (rx_valid && (cyc <= m_e0[i] + ad)) begin
                    m_armed[i] = 1'b0;
                    raise(i, 5);
                end else if (cyc == m_e0[i] + ad + 1) begin
                    m_armed[i] = 1'b0; m_locked[i] = 1'b1; m_trig[i] = 1'b1;
                end
            end else if (m_pos[i] == 0) begin
                if (rx_valid && rx_data == 8'h5A) begin
                    m_pos[i] = 1; m_gap[i] = 0;
                end
            end else if (rx_valid) begin
                m_gap[i] = 0;
                if (m_pos[i] == 1) begin
                    m_cmd[i] = rx_data; m_pos[i] = 2;
                end else if (m_pos[i] == 2) begin
                    m_arg[i] = rx_data; m_pos[i] = 3;
                end else begin
                    m_pos[i] = 0;
                    if (rx_data != (m_cmd[i] ^ m_arg[i]))                raise(i, 1);
                    else if (m_cmd[i] != 8'hB0 && m_cmd[i] != 8'hC1)     raise(i, 2);
                    else if (m_cmd[i] == 8'hB0 && m_arg[i] >= 8'd3)      raise(i, 3);
                    else if (m_cmd[i] == 8'hC1) begin
                        m_flag[i] = 1'b0; m_code[i] = 0; m_cnt[i] = 0;
                    end else begin
                        m_addr[i]  = 32'h0010_0000 + 32'(m_arg[i]) * 32'h0010_0000;
                        m_armed[i] = 1'b1;
                        m_e0[i]    = cyc;
                    end
                end
            end else if (m_gap[i] == 16) begin
                m_pos[i] = 0; m_gap[i] = 0;
                raise(i, 4);
            end else begin
                m_gap[i] = m_gap[i] + 1;
            end
        end
    endtask

    // Compare process: advance the model at each edge, check 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) model_step(i);
            #1;
            for (int i = 0; i < 2; i++) begin
                string p;
                p = (i == 0) ? "a" : "b";
                check({p, ".trig"},  {31'd0, trig[i]},   {31'd0, m_trig[i]});
                check({p, ".addr"},  addr[i],            m_addr[i]);
                check({p, ".busy"},  {31'd0, busy_o[i]}, {31'd0, (m_pos[i] != 0) || m_armed[i] || m_locked[i]});
                check({p, ".flag"},  {31'd0, flag[i]},   {31'd0, m_flag[i]});
                check({p, ".code"},  {29'd0, code[i]},   32'(m_code[i]));
                check({p, ".count"}, {24'd0, cnt[i]},    32'(m_cnt[i]));
            end
        end
    end

    // Trigger pulse counter, cleared by reset.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_seen[0] <= 0;
            trig_seen[1] <= 0;
        end else begin
            if (trig[0]) trig_seen[0] <= trig_seen[0] + 1;
            if (trig[1]) trig_seen[1] <= trig_seen[1] + 1;
        end
    end

    task automatic pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        pulse(8'h5A); pulse(c); pulse(a); pulse(k);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst.trig", {31'd0, trig[i]}, 32'd0);
            check("rst.addr", addr[i], 32'd0);
            check("rst.busy", {31'd0, busy_o[i]}, 32'd0);
            check("rst.count", {24'd0, cnt[i]}, 32'd0);
        end

        // idle noise is dropped silently
        pulse(8'h00); @(negedge clk); pulse(8'hFF); pulse(8'h13);
        repeat (3) @(negedge clk);
        check("noise.count", {24'd0, cnt[0]}, 32'd0);
        check("noise.busy",  {31'd0, busy_o[0]}, 32'd0);

        // valid boot of slot 1: trigger exactly at E0+5 on the short-delay unit
        frame(8'hB0, 8'h01, 8'hB1);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("boot.pulse_a", {31'd0, trig[0]}, {31'd0, n == 5});
        end
        check("boot.addr_a", addr[0], 32'h0020_0000);
        repeat (100) @(negedge clk);
        frame(8'hB0, 8'h00, 8'hB0);
        repeat (10) @(negedge clk);
        check("locked.addr_a", addr[0], 32'h0020_0000);
        check("locked.addr_b", addr[1], 32'h0020_0000);
        check("locked.busy_b", {31'd0, busy_o[1]}, 32'd1);
        check("locked.pulses_a", 32'(trig_seen[0]), 32'd1);
        check("locked.pulses_b", 32'(trig_seen[1]), 32'd1);

        // checksum error, then clear
        do_reset();
        frame(8'hB0, 8'h01, 8'h00);
        @(negedge clk);
        check("chk.code",  {29'd0, code[0]}, 32'd1);
        check("chk.flag",  {31'd0, flag[0]}, 32'd1);
        check("chk.count", {24'd0, cnt[0]},  32'd1);
        check("chk.busy",  {31'd0, busy_o[0]}, 32'd0);
        frame(8'hC1, 8'h00, 8'hC1);
        @(negedge clk);
        check("clr.flag",  {31'd0, flag[0]}, 32'd0);
        check("clr.count", {24'd0, cnt[0]},  32'd0);

        // bad slot, unknown command
        frame(8'hB0, 8'h03, 8'hB3);
        @(negedge clk);
        check("slot.code",  {29'd0, code[1]}, 32'd3);
        check("slot.count", {24'd0, cnt[1]},  32'd1);
        frame(8'h77, 8'h00, 8'h77);
        @(negedge clk);
        check("cmd.code",  {29'd0, code[1]}, 32'd2);
        check("cmd.count", {24'd0, cnt[1]},  32'd2);

        // timeout after SYNC, CMD and a silent gap
        pulse(8'h5A); pulse(8'hB0);
        repeat (17) @(negedge clk);
        check("to.code",  {29'd0, code[0]}, 32'd4);
        check("to.count", {24'd0, cnt[0]},  32'd3);
        check("to.busy",  {31'd0, busy_o[0]}, 32'd0);

        // byte on the exact timeout cycle wins; frame continues to slot 2
        pulse(8'h5A); pulse(8'hB0);
        repeat (16) @(negedge clk);
        pulse(8'h02); pulse(8'hB2);
        check("edge.addr",  addr[0], 32'h0030_0000);
        check("edge.count", {24'd0, cnt[0]}, 32'd3);
        check("edge.busy",  {31'd0, busy_o[0]}, 32'd1);
        repeat (120) @(negedge clk);

        // abort during the long arm delay
        do_reset();
        frame(8'hB0, 8'h00, 8'hB0);
        repeat (19) @(negedge clk);
        pulse(8'h42);
        check("abort.code", {29'd0, code[1]}, 32'd5);
        check("abort.busy", {31'd0, busy_o[1]}, 32'd0);
        repeat (100) @(negedge clk);
        check("abort.pulses_b", 32'(trig_seen[1]), 32'd0);
        check("abort.pulses_a", 32'(trig_seen[0]), 32'd1);

        // reset mid-arm kills the pending trigger
        do_reset();
        frame(8'hB0, 8'h01, 8'hB1);
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.addr", addr[1], 32'd0);
        check("midrst.busy", {31'd0, busy_o[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("midrst.pulses_b", 32'(trig_seen[1]), 32'd0);
        check("midrst.flag", {31'd0, flag[1]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
